// File: rtl/conv_pkg.sv
// Shared state encoding and default sizing for the sequential convolution engine.
package conv_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, EMIT} state_t;

   localparam int CONV_N  = 8;
   localparam int CONV_DW = 8;
   localparam int CONV_OW = 16;

   localparam int NOUT = 2*CONV_N - 1;
   localparam int ACCW = 2*CONV_DW + $clog2(CONV_N);
   localparam int IDXW = $clog2(NOUT);
endpackage

// File: rtl/conv_mac_unit.sv
// Registered multiply-accumulate; one-cycle latency, clr has priority over en.
// No backpressure: the caller gates en.
module conv_mac_unit
   import conv_pkg::*;
#(
   parameter int DW = CONV_DW,
   parameter int AW = ACCW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [AW-1:0] acc
);
   logic [2*DW-1:0] prod;

   assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + AW'(prod);
   end
endmodule

// File: rtl/conv_mac_sequencer.sv
// Sequential linear convolution: loads x/h, runs N*N MACs one per cycle, emits 2N-1 results.
// y[n] appears T(n) cycles after its compute phase starts; result outputs hold until out_ready.
module conv_mac_sequencer
   import conv_pkg::*;
#(
   parameter int N  = CONV_N,
   parameter int DW = CONV_DW,
   parameter int OW = CONV_OW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DW-1:0]            in_x,
   input  logic [DW-1:0]            in_h,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OW-1:0]            out_data,
   output logic [$clog2(2*N-1)-1:0] out_idx
);
   localparam int NRES = 2*N - 1;
   localparam int AW   = 2*DW + $clog2(N);
   localparam int IW   = $clog2(NRES);
   localparam int KW   = $clog2(N);

   state_t        state;
   logic [DW-1:0] x_buf [N];
   logic [DW-1:0] h_buf [N];
   logic [IW-1:0] k, n, n_nxt, k_last, k_first_nxt;
   logic [KW-1:0] h_sel;
   logic [AW-1:0] acc;
   logic          in_hs, out_hs, mac_clr, mac_en;
   logic          unused_acc_hi;

   assign in_hs  = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;
   assign n_nxt  = n + IW'(1);

   // k sweeps max(0,n-N+1)..min(n,N-1) so that h index n-k stays inside the buffer
   assign k_last      = (n < IW'(N)) ? n : IW'(N-1);
   assign k_first_nxt = (n_nxt < IW'(N)) ? '0 : n_nxt - IW'(N-1);
   assign h_sel       = KW'(n - k);

   assign mac_clr = (state == LOAD) || ((state == EMIT) && out_hs);
   assign mac_en  = (state == COMPUTE);

   conv_mac_unit #(.DW(DW), .AW(AW)) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (x_buf[k[KW-1:0]]),
      .b   (h_buf[h_sel]),
      .acc (acc)
   );

   assign out_data      = acc[OW-1:0];
   assign out_idx       = n;
   assign unused_acc_hi = ^acc[AW-1:OW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         k         <= '0;
         n         <= '0;
         for (int i = 0; i < N; i++) begin
            x_buf[i] <= '0;
            h_buf[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  busy     <= 1'b1;
                  in_ready <= 1'b1;
                  k        <= '0;
               end
            end
            LOAD: begin
               if (in_hs) begin
                  x_buf[k[KW-1:0]] <= in_x;
                  h_buf[k[KW-1:0]] <= in_h;
                  if (k == IW'(N-1)) begin
                     state    <= COMPUTE;
                     in_ready <= 1'b0;
                     k        <= '0;
                     n        <= '0;
                  end else begin
                     k <= k + IW'(1);
                  end
               end
            end
            COMPUTE: begin
               if (k == k_last) begin
                  state     <= EMIT;
                  out_valid <= 1'b1;
               end else begin
                  k <= k + IW'(1);
               end
            end
            EMIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (n == IW'(NRES-1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     n     <= n_nxt;
                     k     <= k_first_nxt;
                     state <= COMPUTE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer: sum-of-products model plus scoreboard, checked every cycle.
module tb_conv_mac_sequencer;
   import conv_pkg::*;

   localparam int NS      = CONV_N;
   localparam int M_NONE  = 0;
   localparam int M_BP    = 1;
   localparam int M_SB    = 2;
   localparam int M_ABORT = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                in_valid = 1'b0;
   logic                out_ready = 1'b1;
   logic [CONV_DW-1:0]  in_x = '0;
   logic [CONV_DW-1:0]  in_h = '0;
   logic                busy, done, in_ready, out_valid;
   logic [CONV_OW-1:0]  out_data;
   logic [IDXW-1:0]     out_idx;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_exp = 0;
   int n_done = 0;
   bit done_seen = 0;
   bit hold_prev = 0;
   int xs [NS];
   int hs [NS];
   int got [NOUT];
   int ramp_ref [NOUT] = '{3, 9, 18, 30, 45, 63, 84, 108, 105, 99, 90, 78, 63, 45, 24};
   int exp_dat [$];
   int exp_idx [$];

   conv_mac_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_h      (in_h),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string nm, input longint act, input longint req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // y[n] = sum over every valid k of x[k]*h[n-k], reduced to the output width
   function automatic int model_y(input int n);
      int s = 0;
      for (int j = 0; j < NS; j++)
         if (n - j >= 0 && n - j < NS) s += xs[j] * hs[n - j];
      return s % (1 << CONV_OW);
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 0;
      end else begin
         if (hold_prev) check("valid_held", out_valid, 1);
         if (out_valid) begin
            if (exp_dat.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL spurious_result: idx %0d data %0d, none expected", out_idx, out_data);
            end else begin
               check("out_idx", out_idx, exp_idx[0]);
               check("out_data", out_data, exp_dat[0]);
               if (out_ready) begin
                  got[out_idx] = int'(out_data);
                  void'(exp_dat.pop_front());
                  void'(exp_idx.pop_front());
               end
            end
         end
         hold_prev = out_valid && !out_ready;
         if (done) begin
            n_done++;
            done_seen = 1;
            check("done_cycle", cyc, done_exp);
         end
      end
   end

   task automatic load_seq(input bit gaps, input int extra);
      int i = 0;
      int guard = 0;
      bit ph = 0;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      check("busy_in_load", busy, 1);
      check("in_ready_in_load", in_ready, 1);
      while (i < NS && guard < 40) begin
         in_valid = gaps ? !ph : 1'b1;
         ph = !ph;
         in_x = in_valid ? CONV_DW'(xs[i]) : 8'hEE;
         in_h = in_valid ? CONV_DW'(hs[i]) : 8'hEE;
         @(negedge clk);
         if (in_valid && in_ready) begin
            i++;
            if (i == NS) done_exp = cyc + NS*NS + 2*NS + extra;
         end
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 0;
      check("load_handshakes", i, NS);
   endtask

   task automatic wait_done(input int mode);
      int bp = 0;
      bit st = 0;
      for (int g = 0; g < 300 && !done_seen; g++) begin
         out_ready = 1;
         start = 0;
         if (mode == M_BP && out_valid && (out_idx == 3 || bp > 0) && bp < 5) begin
            out_ready = 0;
            bp++;
            check("bp_hold_data", out_data, 30);
            check("bp_hold_idx", out_idx, 3);
         end
         if (mode == M_SB && !st && busy && !out_valid && out_idx == 2) begin
            start = 1;
            st = 1;
            in_valid = 1;
            in_x = '1;
            in_h = '1;
         end
         if (mode == M_ABORT && busy && !out_valid && out_idx == 5) begin
            rst = 1;
            #1;
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_in_ready", in_ready, 0);
            check("abort_out_valid", out_valid, 0);
            check("abort_out_data", out_data, 0);
            check("abort_out_idx", out_idx, 0);
            exp_dat.delete();
            exp_idx.delete();
            @(posedge clk); #1;
            rst = 0;
            @(posedge clk); #1;
            check("abort_idle_busy", busy, 0);
            check("abort_idle_in_ready", in_ready, 0);
            return;
         end
         @(posedge clk); #1;
      end
      start = 0;
      in_valid = 0;
      out_ready = 1;
   endtask

   task automatic run(input int mode, input bit gaps);
      int extra = (mode == M_BP) ? 5 : 0;
      exp_dat.delete();
      exp_idx.delete();
      for (int n = 0; n < NOUT; n++) begin
         exp_idx.push_back(n);
         exp_dat.push_back(model_y(n));
         got[n] = -1;
      end
      done_seen = 0;
      n_done = 0;
      load_seq(gaps, extra);
      wait_done(mode);
      if (mode != M_ABORT) begin
         check("done_seen", done_seen, 1);
         repeat (3) begin
            @(posedge clk); #1;
         end
         check("done_pulses", n_done, 1);
         check("busy_after", busy, 0);
         check("results_left", exp_dat.size(), 0);
      end
   endtask

   task automatic set_ramp();
      for (int j = 0; j < NS; j++) begin
         xs[j] = j + 1;
         hs[j] = 3;
      end
   endtask

   task automatic check_ramp(input string tag);
      for (int n = 0; n < NOUT; n++) check(tag, got[n], ramp_ref[n]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      rst = 0;
      @(posedge clk); #1;
      check("idle_in_ready", in_ready, 0);

      set_ramp();
      check("model_ramp_y3", model_y(3), 30);
      check("model_ramp_y8", model_y(8), 105);
      run(M_NONE, 0);
      check_ramp("ramp_y");

      for (int j = 0; j < NS; j++) begin
         xs[j] = (j == 0) ? 1 : 0;
         hs[j] = j + 1;
      end
      run(M_NONE, 0);
      for (int n = 0; n < NOUT; n++) check("impulse_y", got[n], (n < NS) ? n + 1 : 0);

      for (int j = 0; j < NS; j++) begin
         xs[j] = 255;
         hs[j] = 255;
      end
      check("model_wrap_y7", model_y(7), 61448);
      run(M_NONE, 0);
      check("wrap_y0", got[0], 65025);
      check("wrap_y7", got[7], 61448);
      check("wrap_y14", got[14], 65025);

      set_ramp();
      run(M_BP, 0);
      check_ramp("bp_y");

      run(M_NONE, 1);
      check_ramp("gaps_y");

      run(M_SB, 0);
      check_ramp("start_busy_y");

      run(M_ABORT, 0);
      run(M_NONE, 0);
      check_ramp("after_abort_y");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
